i2c_write_master: RTL
=====================

# i2c_write_master

Byte-level I2C write engine that sits directly downstream of the HDMI transmitter register-configuration sequencer. It accepts one 3-byte write command: 8-bit slave address byte, 8-bit register address, 8-bit payload. It generates START, 24 data bits with ACK slots, and STOP on the open-drain SDA/SCL pins. It reports completion and ACK status back to the sequencer, which steps through its register table.

## Interface
Parameters:
- CLK_DIV, 62, clock_25 cycles per quarter bit-period. Bit period is 4*CLK_DIV, so 62 gives ≈100.8 kHz. Legal range ≥ 4.
- MAX_RETRY, 3, extra attempts after a NACK. Used only when I2C_RETRY_EN is defined.

Ports:
- clock_25  input  1  system clock, 25 MHz; all logic is on the rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request a transaction; level-sampled in IDLE.
- slave_address  input  8  first byte on the wire, R/W bit included (e.g. 8'h72).
- register_data  input  16  [15:8] register address, [7:0] payload.
- busy  output  1  high from the accept edge until `done`.
- done  output  1  one-cycle pulse at transaction end.
- ack_error  output  1  last transaction saw a NACK; holds until the next accept.
- i2c_serial_data_input  input  1  SDA pin read-back.
- i2c_serial_data_output  output  1  1 = release SDA (high-Z externally), 0 = drive low.
- i2c_serial_clock  output  1  SCL, push-pull.

## Operation
- Reset values: i2c_serial_clock=1, i2c_serial_data_output=1, busy=0, done=0, ack_error=0, state=IDLE, divider=0.
- i2c_serial_data_input passes through a 2-flop synchronizer before use.
- Accept: in IDLE with start=1, the engine latches {slave_address, register_data} into a 24-bit shift register. It then sets busy=1, clears ack_error, clears the divider and enters START.
- While busy, start and all data inputs are ignored.
- A quarter tick occurs when the divider reaches CLK_DIV-1; the divider then wraps to 0. All pin changes happen only on ticks.
- START, 2 quarters: Q0 SCL=1, SDA released. Q1 SCL=1, SDA=0.
- BIT, 4 quarters per bit, MSB first:
  - Q0: SCL=0, SDA set from the shift register (1 = release).
  - Q1: SCL=1.
  - Q2: SCL=1.
  - Q3: SCL=0.
  - After 8 bits the engine goes to ACK.
- ACK, same 4 quarters with SDA released. The synchronized SDA is sampled at Q2.
  - SDA=0 (ACK): go to the next byte, or to STOP after byte 3.
  - SDA=1 (NACK): set ack_error=1, skip the remaining bytes, go to STOP.
- STOP, 4 quarters:
  - Q0: SCL=0, SDA=0.
  - Q1: SCL=1, SDA=0.
  - Q2: SCL=1, SDA released.
  - Q3: idle hold.
  - Then DONE.
- DONE, 1 cycle: done=1, busy=0, return to IDLE.
- State set: IDLE, START, BIT, ACK, STOP, DONE (plus RETRY_WAIT when configured). The engine keeps a bit counter (0–7) and a byte counter (0–2).
- Reset mid-transaction: all outputs return to reset values on the next edge. No STOP is generated; bus recovery is the sequencer's job.

## Timing
- Full transaction with all ACKs: 2+27*4+4 = 114 quarters.
  - done is high in the cycle 114*CLK_DIV+1 cycles after the accept edge.
- NACK on the address byte: 2+9*4+4 = 42 quarters.
- NACK on the register byte: 78 quarters. NACK on the payload byte: 114 quarters.
- SDA changes only while SCL is low, except at START and STOP. Setup time before the SCL rise is 1 quarter.
- ACK sample point is 1 quarter after the SCL rise; the synchronizer adds 2 cycles, which is under CLK_DIV.
- Back-to-back: start held high through DONE is re-accepted in the first IDLE cycle after DONE.

## Configuration
- I2C_RETRY_EN defined:
  - After a NACK transaction's STOP, the engine enters RETRY_WAIT for 4 quarters, then restarts from START with the same latched bytes.
  - It retries up to MAX_RETRY times. busy stays high and done pulses once, at the end of the final attempt.
  - ack_error reflects the final attempt only.
  - The retry counter clears on accept.
- I2C_RETRY_EN undefined: single attempt; a NACK goes directly STOP→DONE with ack_error=1. No RETRY_WAIT state or retry counter is built.

## Test plan
- All-ACK write, CLK_DIV=4, {8'h72,16'h4100}:
  - SDA bit stream is 0x72, A, 0x41, A, 0x00, A with correct START and STOP.
  - done occurs 457 cycles after accept; ack_error=0.
- Address NACK, slave model releases SDA, I2C_RETRY_EN undefined:
  - STOP follows the first ACK slot; done occurs at 42*CLK_DIV+1; ack_error=1.
- Same NACK with I2C_RETRY_EN, MAX_RETRY=3: 4 START conditions, one done, ack_error=1. With ACK on the 3rd attempt: 3 STARTs, ack_error=0.
- start and inputs toggled while busy: no effect on the transmitted bytes; no second transaction until after done.
- reset asserted at quarter 50: next edge shows SCL=1, SDA released, busy=0, done=0. A new start then runs a full 114-quarter transaction.
- Protocol checker, every scenario: SDA never changes while SCL=1 except at START (falling) and STOP (rising).

Source files
------------

// File: rtl/i2c_write_master_if.sv
// Sequencer-facing handshake and I2C pin bundle for i2c_write_master.
// The master modport is the engine's view; the slave modport is the sequencer/bus side.
interface i2c_write_master_if;
    logic        start;
    logic [7:0]  slave_address;
    logic [15:0] register_data;
    logic        busy;
    logic        done;
    logic        ack_error;
    logic        i2c_serial_data_input;
    logic        i2c_serial_data_output;
    logic        i2c_serial_clock;

    modport master (
        input  start, slave_address, register_data, i2c_serial_data_input,
        output busy, done, ack_error, i2c_serial_data_output, i2c_serial_clock
    );

    modport slave (
        output start, slave_address, register_data, i2c_serial_data_input,
        input  busy, done, ack_error, i2c_serial_data_output, i2c_serial_clock
    );
endinterface

// File: rtl/i2c_write_master.sv
// Single-shot 3-byte I2C write engine (START, address, register, payload, STOP).
// Optional NACK retry is built only when the macro I2C_RETRY_EN is defined.
module i2c_write_master #(
    parameter int unsigned CLK_DIV = 62
`ifdef I2C_RETRY_EN
    , parameter int unsigned MAX_RETRY = 3
`endif
) (
    input  logic                clock_25,
    input  logic                reset,
    i2c_write_master_if.master  bus
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
`ifdef I2C_RETRY_EN
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4,
        S_DONE  = 3'd5
`ifdef I2C_RETRY_EN
        , S_RETRY_WAIT = 3'd6
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [23:0]      shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_error_q, ack_error_d;
    logic             scl_q, scl_d;
    logic             sda_q, sda_d;
    logic             sda_meta_q, sda_meta_d;
    logic             sda_sync_q, sda_sync_d;
`ifdef I2C_RETRY_EN
    logic [23:0]        data_q, data_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
`endif
    logic             quarter_tick;
    logic             active;

    // State, counters, pins and SDA synchronizer registers.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            state_q     <= S_IDLE;
            qtr_q       <= 2'd0;
            div_q       <= '0;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 2'd0;
            shift_q     <= 24'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_error_q <= 1'b0;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            sda_meta_q  <= 1'b1;
            sda_sync_q  <= 1'b1;
`ifdef I2C_RETRY_EN
            data_q      <= 24'd0;
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            qtr_q       <= qtr_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ack_error_q <= ack_error_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
            sda_meta_q  <= sda_meta_d;
            sda_sync_q  <= sda_sync_d;
`ifdef I2C_RETRY_EN
            data_q      <= data_d;
            retry_q     <= retry_d;
`endif
        end
    end

    // Next-state, counters and pin levels; pins are derived from the next state so they change with it.
    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ack_error_d = ack_error_q;
        sda_meta_d  = bus.i2c_serial_data_input;
        sda_sync_d  = sda_meta_q;
`ifdef I2C_RETRY_EN
        data_d      = data_q;
        retry_d     = retry_q;
`endif
        active       = (state_q != S_IDLE) && (state_q != S_DONE);
        quarter_tick = active && (div_q == DIV_MAX);

        if (quarter_tick) begin
            div_d = '0;
        end else if (active) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            div_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    shift_d     = {bus.slave_address, bus.register_data};
                    busy_d      = 1'b1;
                    ack_error_d = 1'b0;
                    div_d       = '0;
                    qtr_d       = 2'd0;
                    bit_cnt_d   = 3'd0;
                    byte_cnt_d  = 2'd0;
                    state_d     = S_START;
`ifdef I2C_RETRY_EN
                    data_d      = {bus.slave_address, bus.register_data};
                    retry_d     = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (quarter_tick) begin
                    if (qtr_q == 2'd1) begin
                        qtr_d   = 2'd0;
                        state_d = S_BIT;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_BIT: begin
                if (quarter_tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        shift_d = {shift_q[22:0], 1'b0};
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            state_d   = S_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end else begin
                    state_d = S_BIT;
                end
            end
            S_ACK: begin
                // ack_error doubles as the "abort remaining bytes" flag for this attempt.
                if (quarter_tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd2) begin
                        ack_error_d = ack_error_q | sda_sync_q;
                    end else if (qtr_q == 2'd3) begin
                        if (ack_error_q || (byte_cnt_q == 2'd2)) begin
                            state_d = S_STOP;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            state_d    = S_BIT;
                        end
                    end else begin
                        state_d = S_ACK;
                    end
                end else begin
                    state_d = S_ACK;
                end
            end
            S_STOP: begin
                if (quarter_tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
`ifdef I2C_RETRY_EN
                        if (ack_error_q && (retry_q != RETRY_W'(MAX_RETRY))) begin
                            retry_d = retry_q + RETRY_W'(1);
                            state_d = S_RETRY_WAIT;
                        end else begin
                            state_d = S_DONE;
                        end
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_STOP;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
`ifdef I2C_RETRY_EN
            S_RETRY_WAIT: begin
                if (quarter_tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        shift_d     = data_q;
                        ack_error_d = 1'b0;
                        bit_cnt_d   = 3'd0;
                        byte_cnt_d  = 2'd0;
                        state_d     = S_START;
                    end else begin
                        state_d = S_RETRY_WAIT;
                    end
                end else begin
                    state_d = S_RETRY_WAIT;
                end
            end
`endif
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        scl_d = 1'b1;
        sda_d = 1'b1;
        case (state_d)
            S_START: begin
                sda_d = (qtr_d == 2'd0);
            end
            S_BIT: begin
                scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_d = shift_d[23];
            end
            S_ACK: begin
                scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
            end
            S_STOP: begin
                scl_d = (qtr_d != 2'd0);
                sda_d = qtr_d[1];
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    assign bus.busy                   = busy_q;
    assign bus.done                   = done_q;
    assign bus.ack_error              = ack_error_q;
    assign bus.i2c_serial_clock       = scl_q;
    assign bus.i2c_serial_data_output = sda_q;

endmodule
